// File: rtl/pc_sel_pkg.sv
// Shared types for the next-PC select controller: FSM states, select bit
// indices and the packed one-hot select struct.
package pc_sel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    VECTOR = 2'd2,
    ISR    = 2'd3
  } pc_sel_state_t;

  localparam int SEL_STALL = 0;
  localparam int SEL_BP    = 1;
  localparam int SEL_PCR   = 2;
  localparam int SEL_PCI   = 3;
  localparam int SEL_UNDO  = 4;
  localparam int SEL_ALERT = 5;
  localparam int SEL_W     = 6;

  // Member order matches the SEL_* indices (first member is the MSB).
  typedef struct packed {
    logic alert;
    logic branch_undo;
    logic pci_take;
    logic pcr_take;
    logic branch_predict;
    logic stall;
  } pc_sel_t;

endpackage

// File: rtl/pc_sel_ctrl_irq_edge_sync.sv
// irq_edge_sync: 2-flop synchronizer for an asynchronous level input plus a
// single-cycle rising-edge pulse in the clk domain.
module irq_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/pc_sel_ctrl.sv
// Next-PC select controller: fixed-priority redirect resolution plus the
// interrupt entry/exit FSM. Optional stall watchdog via PC_SEL_STALL_WATCHDOG_EN.
module pc_sel_ctrl
  import pc_sel_pkg::*;
#(
  parameter int STALL_LIMIT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stall_req,
  input  logic       bp_taken,
  input  logic       jr_req,
  input  logic       ji_req,
  input  logic       mispredict,
  input  logic       branch_inflight,
  input  logic       ext_irq,
  input  logic       reti,
  output logic       stall,
  output logic       branch_predict,
  output logic       pcr_take,
  output logic       pci_take,
  output logic       branch_undo,
  output logic       alert,
  output logic       interrupt_mask,
  output logic       flush,
  output logic       irq_pending,
  output logic       stall_timeout,
  output logic [1:0] dbg_state
);

  // Handshake note: there is no valid/ready flow here; every request input is
  // a level sampled each cycle, and select outputs respond in the same cycle.

  pc_sel_state_t r_state;
  pc_sel_state_t w_state_next;
  logic          r_pending;
  logic          r_mask;
  logic          w_irq_rise;
  logic [SEL_W-1:0] w_sel_vec;
  pc_sel_t       w_sel;

  irq_edge_sync u_irq_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (ext_irq),
    .o_rise  (w_irq_rise)
  );

  // Fixed priority: undo > alert > pcr > pci > predict > stall.
  always_comb begin
    w_sel_vec = '0;
    if (mispredict)            w_sel_vec[SEL_UNDO]  = 1'b1;
    else if (r_state == VECTOR) w_sel_vec[SEL_ALERT] = 1'b1;
    else if (jr_req)           w_sel_vec[SEL_PCR]   = 1'b1;
    else if (ji_req)           w_sel_vec[SEL_PCI]   = 1'b1;
    else if (bp_taken)         w_sel_vec[SEL_BP]    = 1'b1;
    else if (stall_req)        w_sel_vec[SEL_STALL] = 1'b1;
  end

  assign w_sel = pc_sel_t'(w_sel_vec);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (r_pending) w_state_next = DRAIN;
      DRAIN:   if (!branch_inflight && !mispredict) w_state_next = VECTOR;
      VECTOR:  if (!mispredict) w_state_next = ISR;
      ISR:     if (reti) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pending <= 1'b0;
      r_mask    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_mask  <= (w_state_next == ISR);
      // A new edge in the vectoring cycle must not be lost.
      if (w_irq_rise)     r_pending <= 1'b1;
      else if (w_sel.alert) r_pending <= 1'b0;
    end
  end

`ifdef PC_SEL_STALL_WATCHDOG_EN
  localparam int CW = $clog2(STALL_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STALL_LIMIT);

  logic [CW-1:0] r_stall_cnt;
  logic [CW-1:0] w_stall_cnt_next;
  logic          r_timeout;

  always_comb begin
    w_stall_cnt_next = r_stall_cnt;
    if (!w_sel.stall)            w_stall_cnt_next = '0;
    else if (r_stall_cnt != LIMIT) w_stall_cnt_next = r_stall_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_stall_cnt <= w_stall_cnt_next;
      if (w_stall_cnt_next == LIMIT) r_timeout <= 1'b1;
    end
  end

  assign stall_timeout = r_timeout;
`else
  logic w_unused_limit;
  assign w_unused_limit = ^STALL_LIMIT;
  assign stall_timeout  = 1'b0;
`endif

  assign stall          = w_sel.stall;
  assign branch_predict = w_sel.branch_predict;
  assign pcr_take       = w_sel.pcr_take;
  assign pci_take       = w_sel.pci_take;
  assign branch_undo    = w_sel.branch_undo;
  assign alert          = w_sel.alert;
  assign flush          = w_sel.branch_undo | w_sel.alert | w_sel.pcr_take | w_sel.pci_take;
  assign interrupt_mask = r_mask;
  assign irq_pending    = r_pending;
  assign dbg_state      = r_state;

endmodule
